// File: rtl/cpu_pkg.sv
// Shared CPU encodings: ALU operations, branch conditions, load/store widths
// and the link register index.
package cpu_pkg;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [1:0] ST_SW = 2'd0;
    localparam logic [1:0] ST_SB = 2'd1;
    localparam logic [1:0] ST_SH = 2'd2;

    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU of the execute stage; shifts act on b.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  logic [3:0]  alu_control,
    output logic [31:0] result
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = b_s >>> shamt;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {31'd0, a_s < b_s};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_LUI:  result = {b[15:0], 16'd0};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_NEXT = 32'd0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_ex_rs,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  id_ex_rd,
    input  logic [4:0]  id_ex_shamt,
    input  logic [31:0] id_ex_imm_sign_extended,
    input  logic [25:0] id_ex_instr_index,
    input  logic [31:0] id_ex_pc_next,
    input  logic [3:0]  id_ex_ctrl_alu_control,
    input  logic        id_ex_ctrl_alu_src,
    input  logic        id_ex_ctrl_alu_shift_shamt,
    input  logic        id_ex_ctrl_branch,
    input  logic [2:0]  id_ex_ctrl_branch_type,
    input  logic        id_ex_ctrl_jump,
    input  logic        id_ex_ctrl_jump_reg,
    input  logic [2:0]  id_ex_ctrl_load_type,
    input  logic [1:0]  id_ex_ctrl_store_type,
    input  logic        id_ex_ctrl_mem_to_reg,
    input  logic        id_ex_ctrl_mem_write,
    input  logic        id_ex_ctrl_reg_dst,
    input  logic        id_ex_ctrl_reg_write,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        mem_wb_reg_write,
    input  logic [4:0]  mem_wb_rd,
    input  logic [31:0] mem_wb_data,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_store_data,
    output logic [31:0] ex_mem_pc_next,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_ctrl_reg_write,
    output logic        ex_mem_ctrl_mem_to_reg,
    output logic        ex_mem_ctrl_mem_write,
    output logic [2:0]  ex_mem_ctrl_load_type,
    output logic [1:0]  ex_mem_ctrl_store_type
);

    // EX/MEM beats MEM/WB because it holds the younger write; $0 is hardwired.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        exm_we,
        input logic [4:0]  exm_rd,
        input logic [31:0] exm_val,
        input logic        wb_we,
        input logic [4:0]  wb_rd,
        input logic [31:0] wb_val
    );
        if (src == 5'd0)                  return 32'd0;
        else if (exm_we && exm_rd == src) return exm_val;
        else if (wb_we && wb_rd == src)   return wb_val;
        else                              return rf_val;
    endfunction

    logic        [31:0] fwd_rs;
    logic        [31:0] fwd_rt;
    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic        [31:0] alu_b;
    logic        [4:0]  alu_shamt;
    logic        [31:0] alu_result;
    logic               br_cond;
    logic               link;
    logic        [31:0] result_p0;
    logic        [4:0]  dest_p0;

    assign rf_raddr1 = id_ex_rs;
    assign rf_raddr2 = id_ex_rt;

    assign fwd_rs = fwd_sel(id_ex_rs, rf_rdata1, ex_mem_ctrl_reg_write, ex_mem_rd,
                            ex_mem_alu_result, mem_wb_reg_write, mem_wb_rd, mem_wb_data);
    assign fwd_rt = fwd_sel(id_ex_rt, rf_rdata2, ex_mem_ctrl_reg_write, ex_mem_rd,
                            ex_mem_alu_result, mem_wb_reg_write, mem_wb_rd, mem_wb_data);
    assign rs_s   = fwd_rs;
    assign rt_s   = fwd_rt;

    assign alu_b     = id_ex_ctrl_alu_src ? id_ex_imm_sign_extended : fwd_rt;
    assign alu_shamt = id_ex_ctrl_alu_shift_shamt ? id_ex_shamt : fwd_rs[4:0];

    alu u_alu (
        .a           (fwd_rs),
        .b           (alu_b),
        .shamt       (alu_shamt),
        .alu_control (id_ex_ctrl_alu_control),
        .result      (alu_result)
    );

    always_comb begin
        br_cond = 1'b0;
        case (id_ex_ctrl_branch_type)
            BR_BEQ:  br_cond = (fwd_rs == fwd_rt);
            BR_BNE:  br_cond = (fwd_rs != fwd_rt);
            BR_BLEZ: br_cond = (rs_s <= 0);
            BR_BGTZ: br_cond = (rs_s > 0);
            BR_BLTZ: br_cond = (rs_s < 0);
            BR_BGEZ: br_cond = (rs_s >= 0);
            default: br_cond = 1'b0;
        endcase
    end

    assign pc_redirect = (id_ex_ctrl_branch & br_cond) | id_ex_ctrl_jump | id_ex_ctrl_jump_reg;

    always_comb begin
        if (id_ex_ctrl_jump_reg)
            pc_target = fwd_rs;
        else if (id_ex_ctrl_jump)
            pc_target = {id_ex_pc_next[31:28], id_ex_instr_index, 2'b00};
        else
            pc_target = id_ex_pc_next + {id_ex_imm_sign_extended[29:0], 2'b00};
    end

    // Jump-and-link writes the return address (PC+4, no delay slot).
    assign link      = (id_ex_ctrl_jump | id_ex_ctrl_jump_reg) & id_ex_ctrl_reg_write;
    assign result_p0 = link ? id_ex_pc_next : alu_result;

    always_comb begin
        if (id_ex_ctrl_reg_dst)
            dest_p0 = id_ex_rd;
        else if (link)
            dest_p0 = LINK_REG;
        else
            dest_p0 = id_ex_rt;
    end

    // EX -> MEM boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_alu_result      <= '0;
            ex_mem_store_data      <= '0;
            ex_mem_pc_next         <= RESET_PC_NEXT;
            ex_mem_rd              <= '0;
            ex_mem_ctrl_reg_write  <= 1'b0;
            ex_mem_ctrl_mem_to_reg <= 1'b0;
            ex_mem_ctrl_mem_write  <= 1'b0;
            ex_mem_ctrl_load_type  <= '0;
            ex_mem_ctrl_store_type <= '0;
        end else begin
            ex_mem_alu_result      <= result_p0;
            ex_mem_store_data      <= fwd_rt;
            ex_mem_pc_next         <= id_ex_pc_next;
            ex_mem_rd              <= dest_p0;
            ex_mem_ctrl_reg_write  <= id_ex_ctrl_reg_write;
            ex_mem_ctrl_mem_to_reg <= id_ex_ctrl_mem_to_reg;
            ex_mem_ctrl_mem_write  <= id_ex_ctrl_mem_write;
            ex_mem_ctrl_load_type  <= id_ex_ctrl_load_type;
            ex_mem_ctrl_store_type <= id_ex_ctrl_store_type;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed test-plan cases followed by random
// instructions, checked against an instruction-level model of the stage.
module tb_ex_stage;

    typedef struct packed {
        logic [4:0]  rs, rt, rd, shamt;
        logic [31:0] imm;
        logic [25:0] idx;
        logic [31:0] pc;
        logic [3:0]  alu;
        logic        alu_src, sh_sh, branch;
        logic [2:0]  btype;
        logic        jump, jr;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic        m2r, mw, rdst, rw;
    } instr_t;

    typedef struct packed {
        logic        redirect;
        logic [31:0] target;
        logic [31:0] result, store, pc;
        logic [4:0]  rd;
        logic        rw, m2r, mw;
        logic [2:0]  lt;
        logic [1:0]  st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [31:0] id_ex_imm_sign_extended;
    logic [25:0] id_ex_instr_index;
    logic [31:0] id_ex_pc_next;
    logic [3:0]  id_ex_ctrl_alu_control;
    logic        id_ex_ctrl_alu_src, id_ex_ctrl_alu_shift_shamt, id_ex_ctrl_branch;
    logic [2:0]  id_ex_ctrl_branch_type;
    logic        id_ex_ctrl_jump, id_ex_ctrl_jump_reg;
    logic [2:0]  id_ex_ctrl_load_type;
    logic [1:0]  id_ex_ctrl_store_type;
    logic        id_ex_ctrl_mem_to_reg, id_ex_ctrl_mem_write, id_ex_ctrl_reg_dst, id_ex_ctrl_reg_write;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data, ex_mem_pc_next;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write;
    logic [2:0]  ex_mem_ctrl_load_type;
    logic [1:0]  ex_mem_ctrl_store_type;

    logic [31:0] rf [32];
    exp_t        comb_q[$];
    exp_t        reg_q[$];
    exp_t        prev;
    int          total  = 0;
    int          passed = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .id_ex_shamt(id_ex_shamt),
        .id_ex_imm_sign_extended(id_ex_imm_sign_extended), .id_ex_instr_index(id_ex_instr_index),
        .id_ex_pc_next(id_ex_pc_next), .id_ex_ctrl_alu_control(id_ex_ctrl_alu_control),
        .id_ex_ctrl_alu_src(id_ex_ctrl_alu_src), .id_ex_ctrl_alu_shift_shamt(id_ex_ctrl_alu_shift_shamt),
        .id_ex_ctrl_branch(id_ex_ctrl_branch), .id_ex_ctrl_branch_type(id_ex_ctrl_branch_type),
        .id_ex_ctrl_jump(id_ex_ctrl_jump), .id_ex_ctrl_jump_reg(id_ex_ctrl_jump_reg),
        .id_ex_ctrl_load_type(id_ex_ctrl_load_type), .id_ex_ctrl_store_type(id_ex_ctrl_store_type),
        .id_ex_ctrl_mem_to_reg(id_ex_ctrl_mem_to_reg), .id_ex_ctrl_mem_write(id_ex_ctrl_mem_write),
        .id_ex_ctrl_reg_dst(id_ex_ctrl_reg_dst), .id_ex_ctrl_reg_write(id_ex_ctrl_reg_write),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
        .pc_redirect(pc_redirect), .pc_target(pc_target),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_pc_next(ex_mem_pc_next), .ex_mem_rd(ex_mem_rd),
        .ex_mem_ctrl_reg_write(ex_mem_ctrl_reg_write), .ex_mem_ctrl_mem_to_reg(ex_mem_ctrl_mem_to_reg),
        .ex_mem_ctrl_mem_write(ex_mem_ctrl_mem_write), .ex_mem_ctrl_load_type(ex_mem_ctrl_load_type),
        .ex_mem_ctrl_store_type(ex_mem_ctrl_store_type)
    );

    always #5 clk = ~clk;

    always_comb rf_rdata1 = rf[rf_raddr1];
    always_comb rf_rdata2 = rf[rf_raddr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        else
            passed++;
    endtask

    // Architectural value of a register as seen by the instruction in EX.
    function automatic logic [31:0] regval(input logic [4:0] s);
        if (s == 0) return 32'd0;
        if (prev.rw && prev.rd == s) return prev.result;
        if (mem_wb_reg_write && mem_wb_rd == s) return mem_wb_data;
        return rf[s];
    endfunction

    function automatic exp_t model(input instr_t i);
        exp_t e;
        logic [31:0] a, t, b;
        logic [4:0]  sh;
        logic [31:0] alu_r;
        logic        cond, is_link;
        a  = regval(i.rs);
        t  = regval(i.rt);
        b  = i.alu_src ? i.imm : t;
        sh = i.sh_sh ? i.shamt : a[4:0];
        case (i.alu)
            4'd0:  alu_r = a & b;
            4'd1:  alu_r = a | b;
            4'd2:  alu_r = a + b;
            4'd3:  alu_r = a ^ b;
            4'd4:  alu_r = ~(a | b);
            4'd5:  alu_r = t << sh;
            4'd6:  alu_r = t >> sh;
            4'd7:  alu_r = $unsigned($signed(t) >>> sh);
            4'd8:  alu_r = a - b;
            4'd9:  alu_r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd10: alu_r = (a < b) ? 32'd1 : 32'd0;
            4'd11: alu_r = b << 16;
            default: alu_r = 32'd0;
        endcase
        case (i.btype)
            3'd0: cond = (a == t);
            3'd1: cond = (a != t);
            3'd2: cond = ($signed(a) <= 0);
            3'd3: cond = ($signed(a) > 0);
            3'd4: cond = ($signed(a) < 0);
            3'd5: cond = ($signed(a) >= 0);
            default: cond = 1'b0;
        endcase
        is_link    = (i.jump || i.jr) && i.rw;
        e.redirect = (i.branch && cond) || i.jump || i.jr;
        if (i.jr)        e.target = a;
        else if (i.jump) e.target = {i.pc[31:28], i.idx, 2'b00};
        else             e.target = i.pc + i.imm * 4;
        e.result = is_link ? i.pc : alu_r;
        e.rd     = i.rdst ? i.rd : (is_link ? 5'd31 : i.rt);
        e.store  = t;
        e.pc     = i.pc;
        e.rw     = i.rw;
        e.m2r    = i.m2r;
        e.mw     = i.mw;
        e.lt     = i.lt;
        e.st     = i.st;
        return e;
    endfunction

    task automatic issue(input instr_t i, input logic we, input logic [4:0] wrd, input logic [31:0] wdata);
        exp_t e;
        {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt} = {i.rs, i.rt, i.rd, i.shamt};
        id_ex_imm_sign_extended    = i.imm;
        id_ex_instr_index          = i.idx;
        id_ex_pc_next              = i.pc;
        id_ex_ctrl_alu_control     = i.alu;
        id_ex_ctrl_alu_src         = i.alu_src;
        id_ex_ctrl_alu_shift_shamt = i.sh_sh;
        id_ex_ctrl_branch          = i.branch;
        id_ex_ctrl_branch_type     = i.btype;
        id_ex_ctrl_jump            = i.jump;
        id_ex_ctrl_jump_reg        = i.jr;
        id_ex_ctrl_load_type       = i.lt;
        id_ex_ctrl_store_type      = i.st;
        id_ex_ctrl_mem_to_reg      = i.m2r;
        id_ex_ctrl_mem_write       = i.mw;
        id_ex_ctrl_reg_dst         = i.rdst;
        id_ex_ctrl_reg_write       = i.rw;
        mem_wb_reg_write           = we;
        mem_wb_rd                  = wrd;
        mem_wb_data                = wdata;
        e = model(i);
        comb_q.push_back(e);
        @(posedge clk);
        reg_q.push_back(e);
        prev = e;
        #1;
    endtask

    task automatic rand_instr(output instr_t i);
        int unsigned kind;
        logic [15:0] r16;
        i       = '0;
        i.rs    = 5'($urandom_range(0, 7));
        i.rt    = 5'($urandom_range(0, 7));
        i.rd    = 5'($urandom_range(0, 7));
        i.shamt = 5'($urandom);
        r16     = 16'($urandom);
        i.imm   = {{16{r16[15]}}, r16};
        i.idx   = 26'($urandom);
        i.pc    = $urandom & 32'hFFFF_FFFC;
        kind    = $urandom_range(0, 9);
        case (kind)
            0, 1: begin
                i.branch = 1'b1;
                i.btype  = 3'($urandom);
            end
            2: begin
                i.jump = 1'b1; i.rw = 1'($urandom); i.rdst = 1'($urandom);
            end
            3: begin
                i.jr = 1'b1; i.rw = 1'($urandom); i.rdst = 1'($urandom);
            end
            4: i = '0;
            default: begin
                i.alu     = 4'($urandom);
                i.alu_src = (i.alu >= 4'd5 && i.alu <= 4'd7) ? 1'b0 : 1'($urandom);
                i.sh_sh   = 1'($urandom);
                i.rdst    = 1'($urandom);
                i.rw      = 1'($urandom);
                i.mw      = 1'($urandom);
                i.m2r     = 1'($urandom);
                i.lt      = 3'($urandom);
                i.st      = 2'($urandom);
            end
        endcase
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " alu_result"}, ex_mem_alu_result, 32'd0);
        chk({tag, " store_data"}, ex_mem_store_data, 32'd0);
        chk({tag, " pc_next"},    ex_mem_pc_next,    32'd0);
        chk({tag, " rd"},         ex_mem_rd,         32'd0);
        chk({tag, " ctrl"}, {ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write,
                             ex_mem_ctrl_load_type, ex_mem_ctrl_store_type}, 32'd0);
    endtask

    // Monitor: combinational redirect for the instruction now in EX, and the
    // EX/MEM bundle captured from the previous instruction.
    always @(negedge clk) begin
        exp_t e;
        if (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            chk("pc_redirect", pc_redirect, e.redirect);
            if (e.redirect) chk("pc_target", pc_target, e.target);
        end
        if (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            chk("ex_mem_alu_result", ex_mem_alu_result, e.result);
            chk("ex_mem_store_data", ex_mem_store_data, e.store);
            chk("ex_mem_pc_next",    ex_mem_pc_next,    e.pc);
            chk("ex_mem_rd",         ex_mem_rd,         e.rd);
            chk("ex_mem_ctrl", {ex_mem_ctrl_reg_write, ex_mem_ctrl_mem_to_reg, ex_mem_ctrl_mem_write,
                                ex_mem_ctrl_load_type, ex_mem_ctrl_store_type},
                               {e.rw, e.m2r, e.mw, e.lt, e.st});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i;
        prev  = '0;
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        i = '0;
        issue_idle(i);
        #1;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // add $8, $0, 5  then  add $9, $8, $8 while MEM/WB writes 9 to $8
        i = '0; i.alu = 4'd2; i.alu_src = 1'b1; i.imm = 32'd5; i.rt = 5'd8; i.rw = 1'b1; i.pc = 32'h100;
        issue(i, 1'b0, 5'd0, 32'd0);
        i = '0; i.alu = 4'd2; i.rs = 5'd8; i.rt = 5'd8; i.rd = 5'd9; i.rdst = 1'b1; i.rw = 1'b1; i.pc = 32'h104;
        issue(i, 1'b1, 5'd8, 32'd9);
        // $0 never forwarded from MEM/WB
        rf[0] = 32'hDEAD_BEEF;
        i = '0; i.alu = 4'd1; i.rs = 5'd0; i.rt = 5'd0; i.rd = 5'd10; i.rdst = 1'b1; i.rw = 1'b1;
        issue(i, 1'b1, 5'd0, 32'hFFFF_FFFF);
        // BEQ taken, BNE not taken
        rf[3] = 32'h1234_5678;
        i = '0; i.branch = 1'b1; i.btype = 3'd0; i.rs = 5'd3; i.rt = 5'd3; i.pc = 32'h40; i.imm = 32'hFFFF_FFFC;
        issue(i, 1'b0, 5'd0, 32'd0);
        i.btype = 3'd1;
        issue(i, 1'b0, 5'd0, 32'd0);
        // j and jalr
        i = '0; i.jump = 1'b1; i.pc = 32'h1000_0040; i.idx = 26'h20;
        issue(i, 1'b0, 5'd0, 32'd0);
        rf[5] = 32'h200;
        i = '0; i.jr = 1'b1; i.rs = 5'd5; i.rd = 5'd31; i.rdst = 1'b1; i.rw = 1'b1; i.pc = 32'h1000_0044;
        issue(i, 1'b0, 5'd0, 32'd0);
        // ALU corners: SRA, SLT, SLTU, ADD wrap
        rf[6] = 32'h8000_0000; rf[1] = 32'hFFFF_FFFF; rf[2] = 32'd1;
        i = '0; i.alu = 4'd7; i.rt = 5'd6; i.shamt = 5'd4; i.sh_sh = 1'b1; i.rd = 5'd20; i.rdst = 1'b1; i.rw = 1'b1;
        issue(i, 1'b0, 5'd0, 32'd0);
        i = '0; i.alu = 4'd9; i.rs = 5'd1; i.rt = 5'd2; i.rd = 5'd21; i.rdst = 1'b1; i.rw = 1'b1;
        issue(i, 1'b0, 5'd0, 32'd0);
        i.alu = 4'd10;
        issue(i, 1'b0, 5'd0, 32'd0);
        i.alu = 4'd2;
        issue(i, 1'b0, 5'd0, 32'd0);

        // Random traffic with a mid-stream reset
        for (int n = 0; n < 400; n++) begin
            instr_t r;
            logic [31:0] v;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: v = 32'd0;
                    1: v = 32'd1;
                    2: v = 32'hFFFF_FFFF;
                    3: v = 32'h8000_0000;
                    default: v = $urandom;
                endcase
                rf[$urandom_range(0, 7)] = v;
            end
            rand_instr(r);
            issue(r, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            if (n == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk_reset("async reset");
                comb_q.delete();
                reg_q.delete();
                prev = '0;
                @(posedge clk);
                #1;
                chk_reset("held reset");
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        if (comb_q.size() != 0 || reg_q.size() != 0)
            chk("scoreboard drained", comb_q.size() + reg_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic issue_idle(input instr_t i);
        {id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt} = {i.rs, i.rt, i.rd, i.shamt};
        id_ex_imm_sign_extended    = i.imm;
        id_ex_instr_index          = i.idx;
        id_ex_pc_next              = i.pc;
        id_ex_ctrl_alu_control     = i.alu;
        id_ex_ctrl_alu_src         = i.alu_src;
        id_ex_ctrl_alu_shift_shamt = i.sh_sh;
        id_ex_ctrl_branch          = i.branch;
        id_ex_ctrl_branch_type     = i.btype;
        id_ex_ctrl_jump            = i.jump;
        id_ex_ctrl_jump_reg        = i.jr;
        id_ex_ctrl_load_type       = i.lt;
        id_ex_ctrl_store_type      = i.st;
        id_ex_ctrl_mem_to_reg      = i.m2r;
        id_ex_ctrl_mem_write       = i.mw;
        id_ex_ctrl_reg_dst         = i.rdst;
        id_ex_ctrl_reg_write       = i.rw;
        mem_wb_reg_write           = 1'b0;
        mem_wb_rd                  = 5'd0;
        mem_wb_data                = 32'd0;
    endtask

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage. Consumes the registered `id_ex_*` bundle, reads the register file, and forwards from EX/MEM and MEM/WB. It runs the ALU, resolves branches and jumps (driving the redirect/flush back to IF/ID), and registers the EX/MEM bundle for the memory stage.

## Interface
- `RESET_PC_NEXT`, 32'd0: value of `ex_mem_pc_next` after reset.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_ex_rs`, `id_ex_rt`, `id_ex_rd`, `id_ex_shamt`  in  5 each  decoded register fields and shift amount.
- `id_ex_imm_sign_extended`  in  32  sign-extended immediate.
- `id_ex_instr_index`  in  26  J-format target field, registered in ID/EX with the rest of the bundle.
- `id_ex_pc_next`  in  32  PC+4 of the instruction in EX.
- `id_ex_ctrl_*`  in  various  alu_control[3:0], alu_src, alu_shift_shamt, branch, branch_type[2:0], jump, jump_reg, load_type[2:0], store_type[1:0], mem_to_reg, mem_write, reg_dst, reg_write.
- `rf_raddr1`, `rf_raddr2`  out  5  register-file read addresses (= `id_ex_rs`, `id_ex_rt`).
- `rf_rdata1`, `rf_rdata2`  in  32  combinational read data; the register file does not bypass.
- `mem_wb_reg_write`  in  1  WB write enable.
- `mem_wb_rd`  in  5  WB destination.
- `mem_wb_data`  in  32  WB write data.
- `pc_redirect`  out  1  taken branch or jump in EX; also the flush request to IF and ID (`flush_id`).
- `pc_target`  out  32  redirect address.
- `ex_mem_alu_result`, `ex_mem_store_data`, `ex_mem_pc_next`  out  32  registered outputs.
- `ex_mem_rd`  out  5  registered final destination register.
- `ex_mem_ctrl_reg_write`, `ex_mem_ctrl_mem_to_reg`, `ex_mem_ctrl_mem_write`  out  1  registered controls.
- `ex_mem_ctrl_load_type`  out  3  registered.
- `ex_mem_ctrl_store_type`  out  2  registered.

## Operation
- **Operand forwarding**, per source `s` in {rs, rt}:
  - If `s==0`: value 0.
  - Else if `ex_mem_ctrl_reg_write && ex_mem_rd==s`: `ex_mem_alu_result`.
  - Else if `mem_wb_reg_write && mem_wb_rd==s`: `mem_wb_data`.
  - Else: `rf_rdataN`.
  - EX/MEM has priority over MEM/WB. Load-use is covered by the one-cycle bubble the decode stage inserts, so EX/MEM never holds un-loaded data for a dependent instruction.
- **Operand selection:**
  - A = fwd_rs.
  - B = alu_src ? imm : fwd_rt.
  - Shift amount = alu_shift_shamt ? shamt : fwd_rs[4:0]. The shifted operand is fwd_rt.
- **ALU codes** (cpu_pkg):
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 SUB, 9 SLT (signed), 10 SLTU, 11 LUI (B<<16).
  - Codes 12-15 yield 0.
  - ADD and SUB wrap modulo 2^32; no overflow trap.
- **Branch types:** 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ. Signed comparisons of fwd_rs against fwd_rt or against zero.
- **taken** = branch & cond | jump | jump_reg.
- **Redirect target:**
  - Branch: pc_next + (imm<<2).
  - jump_reg: fwd_rs.
  - jump: {pc_next[31:28], instr_index, 2'b00}.
  - Branch and jump are mutually exclusive by decode.
- **Link:** no delay slot. When jump/jump_reg is set with reg_write, result = id_ex_pc_next.
  - Destination is 31 if !reg_dst, else rd.
  - Otherwise destination = reg_dst ? rd : rt.
- **Store data:** `ex_mem_store_data` = fwd_rt.

## Timing
- Redirect is combinational from ID/EX and forwarding inputs: `pc_redirect`/`pc_target` are valid in the same cycle the instruction is in EX. IF/ID flush on the following edge, costing 2 bubbles per taken branch or jump.
- EX/MEM registers update every rising edge; there is no stall or enable, since bubbles arrive as all-zero `id_ex` bundles.
- A bubble (all zeros) produces reg_write=0, mem_write=0 and redirect=0.
- **Reset (async):** all `ex_mem_*` go to 0, except `ex_mem_pc_next`, which goes to `RESET_PC_NEXT`. Reset mid-operation discards the in-flight instruction.
- A taken branch in EX is itself still written to EX/MEM, harmless because its controls are 0. A jump-and-link commits normally.
- If EX/MEM and MEM/WB both target the same register, EX/MEM wins.
- A MEM/WB write to $0 is never forwarded.

## Structure
- `cpu_pkg`: ALU codes, branch-type codes, load/store type codes, link register constant 31. This package is shared with `control` and `id_stage`.
- One sub-module, `alu` (combinational: a, b, shamt, alu_control → result).
- Forwarding, branch compare and the EX/MEM registers live in `ex_stage`.

## Test plan
- **Forwarding:** `add $t0` writes 5 in EX/MEM while MEM/WB writes 9 to $t0, then `add $t1,$t0,$t0` → result 10.
- **$0 forwarding:** MEM/WB reg_write=1, rd=0, data=0xFFFF_FFFF → reading $0 gives 0.
- **BEQ taken:** equal operands, pc_next=0x40, imm=-4 → pc_redirect=1, pc_target=0x30.
- **BNE not taken:** equal operands → pc_redirect=0.
- **Jump:** pc_next=0x1000_0040, instr_index=0x20 → target 0x1000_0080. jalr rs=0x200, rd=31 → target 0x200, ex_mem_alu_result=pc_next, ex_mem_rd=31.
- **ALU corner cases:**
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - SLT -1 < 1 → 1.
  - SLTU gives 0 for the same operands.
  - ADD 0xFFFF_FFFF + 1 → 0, with no trap.
- **Reset:** assert `rst_n` low mid-stream → all ex_mem outputs 0 asynchronously.
